vending_machine_multi: RTL and testbench

Parametrised multi-item vending controller, the next generation of the single-product `vending_machine`. It accumulates coin credit and vends one of `NUM_ITEMS` products at per-item prices. Change is returned one coin per cycle, largest denomination first, and a cancel path refunds the full credit. It sits between the coin acceptor front end (`in` coin codes) and the dispenser/coin-hopper drivers.

---
 rtl/vending_machine_multi.sv | 168 ++++++++++++++++
 tb/tb_vending_machine_multi.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
// vending_machine_multi
// Multi-item vending controller. It adds coin credit up to a ceiling and
// vends one of NUM_ITEMS products at per-item prices. Change and refunds
// are paid out one coin per cycle, using the largest coin first.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   in        - coin code this cycle (00 none, 01 COIN1, 10 COIN2, 11 COIN3)
//   sel       - item index, sampled with sel_valid
//   sel_valid - purchase request strobe
//   cancel    - refund request strobe
//   out       - one-cycle dispense pulse
//   item      - vended item index while out is high, 0 otherwise
//   change    - returned coin code, 00 when no coin
//   credit    - registered credit
//   deny      - one-cycle pulse for a refused purchase
//   reject    - one-cycle pulse for a coin that was not credited
//   busy      - high while vending or paying out change
module vending_machine_multi #(
  parameter int CREDIT_W   = 8,
  parameter int NUM_ITEMS  = 4,
  parameter int SEL_W      = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd45, 8'd30, 8'd20, 8'd15},
  parameter int COIN1      = 5,
  parameter int COIN2      = 10,
  parameter int COIN3      = 20,
  parameter int MAX_CREDIT = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_valid,
  input  logic                cancel,
  output logic                out,
  output logic [SEL_W-1:0]    item,
  output logic [1:0]          change,
  output logic [CREDIT_W-1:0] credit,
  output logic                deny,
  output logic                reject,
  output logic                busy
);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W-1:0] C1      = CREDIT_W'(COIN1);
  localparam logic [CREDIT_W-1:0] C2      = CREDIT_W'(COIN2);
  localparam logic [CREDIT_W-1:0] C3      = CREDIT_W'(COIN3);
  localparam logic [CREDIT_W:0]   MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] price;
  logic                sel_ok;
  logic [1:0]          refund_code;
  logic [CREDIT_W-1:0] refund_val;

  // Value of the inserted coin. The sum has one extra bit so that an
  // overflow past the ceiling cannot wrap around and look affordable.
  always_comb begin
    coin_val = '0;
    case (in)
      2'b01:   coin_val = C1;
      2'b10:   coin_val = C2;
      2'b11:   coin_val = C3;
      default: coin_val = '0;
    endcase
    sum       = {1'b0, credit} + {1'b0, coin_val};
    coin_fits = (sum <= MAX_EXT);
  end

  // Price lookup. An out-of-range select gives price 0. It is refused
  // through sel_ok, so the part-select never goes past the end of PRICES.
  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i)) price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
    sel_ok = (32'(sel) < NUM_ITEMS);
  end

  // Largest coin that still fits in the remaining credit. A remainder
  // smaller than COIN1 cannot occur with legal parameters. If one does,
  // it is cleared so the payout still ends.
  always_comb begin
    refund_code = 2'b00;
    refund_val  = credit;
    if (credit >= C3) begin
      refund_code = 2'b11;
      refund_val  = C3;
    end else if (credit >= C2) begin
      refund_code = 2'b10;
      refund_val  = C2;
    end else if (credit >= C1) begin
      refund_code = 2'b01;
      refund_val  = C1;
    end
  end

  // Main controller. All outputs are registered here.
  // out, item, change, deny and reject default to 0 every cycle, so each
  // of them is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= COLLECT;
      out    <= 1'b0;
      item   <= '0;
      change <= 2'b00;
      credit <= '0;
      deny   <= 1'b0;
      reject <= 1'b0;
      busy   <= 1'b0;
    end else begin
      out    <= 1'b0;
      item   <= '0;
      change <= 2'b00;
      deny   <= 1'b0;
      reject <= 1'b0;
      case (state)
        COLLECT: begin
          if (cancel && credit != '0) begin
            // The first refund coin appears one cycle later, from CHANGE.
            reject <= (in != 2'b00);
            busy   <= 1'b1;
            state  <= CHANGE;
          end else if (sel_valid) begin
            // The purchase is judged on the credit before any coin this
            // cycle. That coin is turned away.
            reject <= (in != 2'b00);
            if (sel_ok && credit >= price) begin
              credit <= credit - price;
              item   <= sel;
              out    <= 1'b1;
              busy   <= 1'b1;
              state  <= VEND;
            end else begin
              deny <= 1'b1;
            end
          end else if (in != 2'b00) begin
            if (coin_fits) credit <= sum[CREDIT_W-1:0];
            else           reject <= 1'b1;
          end
        end
        VEND, CHANGE: begin
          // Leaving VEND pays out the first change coin straight away.
          // CHANGE keeps paying until the credit is empty, then drops busy.
          reject <= (in != 2'b00);
          if (credit != '0) begin
            change <= refund_code;
            credit <= credit - refund_val;
            state  <= CHANGE;
          end else begin
            busy  <= 1'b0;
            state <= COLLECT;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi
// Directed bench for vending_machine_multi. It drives the default
// four-item configuration, plus a three-item instance for out-of-range
// selects. Expected values are worked out by hand from the prices
// 15/20/30/45 and the coin values 5/10/20.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in;
  logic [1:0] sel;
  logic       sel_valid;
  logic       cancel;
  logic       out;
  logic [1:0] item;
  logic [1:0] change;
  logic [7:0] credit;
  logic       deny, reject, busy;

  logic [1:0] in3;
  logic [1:0] sel3;
  logic       sel_valid3;
  logic       cancel3;
  logic       out3;
  logic [1:0] item3;
  logic [1:0] change3;
  logic [7:0] credit3;
  logic       deny3, reject3, busy3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .sel_valid(sel_valid),
    .cancel(cancel), .out(out), .item(item), .change(change),
    .credit(credit), .deny(deny), .reject(reject), .busy(busy)
  );

  // Three-item variant (prices 15/20/30), so that sel=3 is out of range.
  vending_machine_multi #(.NUM_ITEMS(3), .PRICES({8'd30, 8'd20, 8'd15})) dut3 (
    .clk(clk), .rst(rst), .in(in3), .sel(sel3), .sel_valid(sel_valid3),
    .cancel(cancel3), .out(out3), .item(item3), .change(change3),
    .credit(credit3), .deny(deny3), .reject(reject3), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in = 2'b00; sel = 2'b00; sel_valid = 1'b0; cancel = 1'b0;
    in3 = 2'b00; sel3 = 2'b00; sel_valid3 = 1'b0; cancel3 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic coin(input logic [1:0] c);
    in = c;
    tick();
    in = 2'b00;
  endtask

  task automatic coin3(input logic [1:0] c);
    in3 = c;
    tick();
    in3 = 2'b00;
  endtask

  task automatic buy(input logic [1:0] s);
    sel = s; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({out, item, change, credit, deny, reject, busy} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h want 0000", {out, item, change, credit, deny, reject, busy});
    end
    checks++;
    if ({out3, item3, change3, credit3, deny3, reject3, busy3} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs3: got %h want 0000", {out3, item3, change3, credit3, deny3, reject3, busy3});
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({credit, busy, change} !== 11'h0) begin
      errors++;
      $display("[TB] FAIL reset_release: got credit=%0d busy=%b change=%b want 0/0/00", credit, busy, change);
    end
  endtask

  task automatic test_exact_payment();
    do_reset();
    coin(2'b01);
    checks++;
    if (credit !== 8'd5) begin
      errors++;
      $display("[TB] FAIL exact_coin1: got %0d want 5", credit);
    end
    coin(2'b10);
    checks++;
    if (credit !== 8'd15) begin
      errors++;
      $display("[TB] FAIL exact_coin2: got %0d want 15", credit);
    end
    buy(2'b00);
    checks++;
    if ({out, item, credit, busy, change} !== {1'b1, 2'd0, 8'd0, 1'b1, 2'b00}) begin
      errors++;
      $display("[TB] FAIL exact_vend: got out=%b item=%0d credit=%0d busy=%b change=%b want 1/0/0/1/00", out, item, credit, busy, change);
    end
    tick();
    checks++;
    if ({out, busy, change, credit} !== 12'h0) begin
      errors++;
      $display("[TB] FAIL exact_done: got out=%b busy=%b change=%b credit=%0d want 0/0/00/0", out, busy, change, credit);
    end
  endtask

  task automatic test_change_return();
    do_reset();
    coin(2'b11);
    coin(2'b11);
    checks++;
    if (credit !== 8'd40) begin
      errors++;
      $display("[TB] FAIL change_credit: got %0d want 40", credit);
    end
    buy(2'b00);
    checks++;
    if ({out, item, credit, change, busy} !== {1'b1, 2'd0, 8'd25, 2'b00, 1'b1}) begin
      errors++;
      $display("[TB] FAIL change_vend: got out=%b item=%0d credit=%0d change=%b busy=%b want 1/0/25/00/1", out, item, credit, change, busy);
    end
    tick();
    checks++;
    if ({change, credit, out, busy} !== {2'b11, 8'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL change_first: got change=%b credit=%0d out=%b busy=%b want 11/5/0/1", change, credit, out, busy);
    end
    // A coin offered while change is paying out must be turned away.
    coin(2'b01);
    checks++;
    if ({change, credit, reject, busy} !== {2'b01, 8'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL change_second: got change=%b credit=%0d reject=%b busy=%b want 01/0/1/1", change, credit, reject, busy);
    end
    tick();
    checks++;
    if ({change, credit, busy, reject} !== 12'h0) begin
      errors++;
      $display("[TB] FAIL change_done: got change=%b credit=%0d busy=%b reject=%b want 00/0/0/0", change, credit, busy, reject);
    end
  endtask

  task automatic test_deny();
    do_reset();
    coin(2'b10);
    buy(2'b01);
    checks++;
    if ({deny, out, credit, busy} !== {1'b1, 1'b0, 8'd10, 1'b0}) begin
      errors++;
      $display("[TB] FAIL deny_poor: got deny=%b out=%b credit=%0d busy=%b want 1/0/10/0", deny, out, credit, busy);
    end
    tick();
    checks++;
    if ({deny, credit} !== {1'b0, 8'd10}) begin
      errors++;
      $display("[TB] FAIL deny_pulse: got deny=%b credit=%0d want 0/10", deny, credit);
    end
    coin3(2'b11);
    coin3(2'b11);
    sel3 = 2'd3; sel_valid3 = 1'b1;
    tick();
    sel_valid3 = 1'b0;
    checks++;
    if ({deny3, out3, credit3} !== {1'b1, 1'b0, 8'd40}) begin
      errors++;
      $display("[TB] FAIL deny_range: got deny=%b out=%b credit=%0d want 1/0/40", deny3, out3, credit3);
    end
    sel3 = 2'd2; sel_valid3 = 1'b1;
    tick();
    sel_valid3 = 1'b0;
    checks++;
    if ({out3, item3, credit3, deny3} !== {1'b1, 2'd2, 8'd10, 1'b0}) begin
      errors++;
      $display("[TB] FAIL last_item: got out=%b item=%0d credit=%0d deny=%b want 1/2/10/0", out3, item3, credit3, deny3);
    end
  endtask

  task automatic test_cancel();
    logic [1:0] exp_chg [0:4] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
    logic [7:0] exp_crd [0:4] = '{8'd35, 8'd15, 8'd5, 8'd0, 8'd0};
    logic       exp_bsy [0:4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    coin(2'b11);
    coin(2'b10);
    coin(2'b01);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if ({change, credit, busy, out} !== {exp_chg[i], exp_crd[i], exp_bsy[i], 1'b0}) begin
        errors++;
        $display("[TB] FAIL cancel_step%0d: got change=%b credit=%0d busy=%b out=%b want %b/%0d/%b/0", i, change, credit, busy, out, exp_chg[i], exp_crd[i], exp_bsy[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (4) coin(2'b11);
    coin(2'b10);
    coin(2'b11);
    checks++;
    if ({reject, credit} !== {1'b1, 8'd90}) begin
      errors++;
      $display("[TB] FAIL overflow_reject: got reject=%b credit=%0d want 1/90", reject, credit);
    end
    coin(2'b01);
    coin(2'b01);
    checks++;
    if ({reject, credit} !== {1'b0, 8'd100}) begin
      errors++;
      $display("[TB] FAIL ceiling_accept: got reject=%b credit=%0d want 0/100", reject, credit);
    end
    coin(2'b01);
    checks++;
    if ({reject, credit} !== {1'b1, 8'd100}) begin
      errors++;
      $display("[TB] FAIL ceiling_reject: got reject=%b credit=%0d want 1/100", reject, credit);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    coin(2'b10);
    coin(2'b01);
    in = 2'b01;
    buy(2'b00);
    in = 2'b00;
    checks++;
    if ({out, reject, credit, busy} !== {1'b1, 1'b1, 8'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL coin_with_sel: got out=%b reject=%b credit=%0d busy=%b want 1/1/0/1", out, reject, credit, busy);
    end
    tick();
    coin(2'b10);
    in = 2'b10;
    buy(2'b01);
    in = 2'b00;
    checks++;
    if ({deny, reject, credit, out} !== {1'b1, 1'b1, 8'd10, 1'b0}) begin
      errors++;
      $display("[TB] FAIL coin_with_deny: got deny=%b reject=%b credit=%0d out=%b want 1/1/10/0", deny, reject, credit, out);
    end
    do_reset();
    cancel = 1'b1; in = 2'b01;
    tick();
    cancel = 1'b0; in = 2'b00;
    checks++;
    if ({credit, reject, busy} !== {8'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL idle_cancel_coin: got credit=%0d reject=%b busy=%b want 5/0/0", credit, reject, busy);
    end
    cancel = 1'b1; in = 2'b10;
    tick();
    cancel = 1'b0; in = 2'b00;
    checks++;
    if ({credit, reject, busy} !== {8'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL cancel_coin: got credit=%0d reject=%b busy=%b want 5/1/1", credit, reject, busy);
    end
    buy(2'b00);
    checks++;
    if ({change, credit, deny, out} !== {2'b01, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sel_in_change: got change=%b credit=%0d deny=%b out=%b want 01/0/0/0", change, credit, deny, out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    coin(2'b10);
    coin(2'b01);
    buy(2'b00);
    tick();
    checks++;
    if ({busy, out} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got busy=%b out=%b want 0/0", busy, out);
    end
    buy(2'b01);
    checks++;
    if ({deny, out} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_first_collect: got deny=%b out=%b want 1/0", deny, out);
    end
    coin(2'b11);
    buy(2'b01);
    checks++;
    if ({out, item, credit} !== {1'b1, 2'd1, 8'd0}) begin
      errors++;
      $display("[TB] FAIL b2b_vend: got out=%b item=%0d credit=%0d want 1/1/0", out, item, credit);
    end
    tick();
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    coin(2'b11);
    coin(2'b11);
    buy(2'b00);
    tick();
    checks++;
    if ({change, credit} !== {2'b11, 8'd5}) begin
      errors++;
      $display("[TB] FAIL midrst_first_coin: got change=%b credit=%0d want 11/5", change, credit);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out, item, change, credit, deny, reject, busy} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got %h want 0000", {out, item, change, credit, deny, reject, busy});
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({credit, busy, change} !== 11'h0) begin
      errors++;
      $display("[TB] FAIL midrst_release: got credit=%0d busy=%b change=%b want 0/0/00", credit, busy, change);
    end
    coin(2'b01);
    checks++;
    if ({credit, reject} !== {8'd5, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midrst_collect: got credit=%0d reject=%b want 5/0", credit, reject);
    end
  endtask

  initial begin
    test_reset();
    test_exact_payment();
    test_change_return();
    test_deny();
    test_cancel();
    test_overflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
